instr_trace_buffer: RTL and testbench

- Sits directly downstream of the multicycle CPU's `data_out_instruction` output and captures every fetched instruction word into a FIFO trace buffer.
- The trace drains through a valid/ready read port to a bench or debug reader.
- Counts instruction words dropped on overflow.
- Freezes capture when a programmable halt word is fetched.
- Drives the board `led` as a stretched "instruction fetched" activity pulse.

---
 rtl/instr_trace_buffer_if.sv | 20 ++
 rtl/instr_trace_buffer.sv | 129 ++++++++++++
 tb/tb_instr_trace_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_trace_buffer_if.sv
// Capture and read-port signals of the instruction trace buffer.
// master = CPU fetch side plus trace reader, slave = the buffer itself.
interface instr_trace_buffer_if;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        freeze_clr;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;

  modport master (
    output instr_in, instr_valid, freeze_clr, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  instr_in, instr_valid, freeze_clr, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/instr_trace_buffer.sv
// Instruction trace FIFO sitting behind the CPU fetch stage.
// Captures fetched words, drains them through a first-word-fall-through read
// port, counts overflow drops, freezes on a halt word and stretches an
// activity pulse onto the board led.
//
// state   | meaning
// CAPTURE | fetched words are pushed (or dropped and counted when full)
// FROZEN  | fetched words are ignored until freeze_clr; reads still drain
module instr_trace_buffer #(
  parameter int          DEPTH     = 16,
  parameter int          ADDR_W    = 4,
  parameter int          STRETCH   = 8,
  parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
  input  logic                 CLK,
  input  logic                 reset,
  instr_trace_buffer_if.slave  bus,
  output logic [ADDR_W:0]      count,
  output logic [15:0]          overflow_cnt,
  output logic                 frozen,
  output logic                 led
);

  localparam int              LED_W    = $clog2(STRETCH + 1);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic {
    CAPTURE = 1'b0,
    FROZEN  = 1'b1
  } state_t;

  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_nxt;
  logic [31:0]       rd_data_q;
  logic [LED_W-1:0]  led_cnt;
  logic              full;
  logic              pop;
  logic              attempt;
  logic              push;
  logic              drop;

  assign bus.rd_valid = (count != '0);
  assign bus.rd_data  = rd_data_q;

  // Handshake decode: a full buffer still accepts a word when it pops the same cycle.
  always_comb begin
    full       = (count == CNT_FULL);
    pop        = bus.rd_valid & bus.rd_ready;
    attempt    = (state == CAPTURE) & bus.instr_valid;
    push       = attempt & (~full | pop);
    drop       = attempt & full & ~pop;
    rd_ptr_nxt = rd_ptr + ADDR_W'(1);
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.instr_in;
  end

  // Pointers, occupancy, registered read head, freeze FSM, drop counter and led stretch.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state        <= CAPTURE;
      frozen       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_data_q    <= '0;
      overflow_cnt <= '0;
      led_cnt      <= '0;
      led          <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;

      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // With one entry left, the next head is the word being written right now,
      // which the array does not yet hold, so it is taken straight from the input.
      if (pop) begin
        if (count == CNT_ONE) begin
          if (push) rd_data_q <= bus.instr_in;
        end else begin
          rd_data_q <= mem[rd_ptr_nxt];
        end
      end else if (push && count == '0) begin
        rd_data_q <= bus.instr_in;
      end

      case (state)
        CAPTURE: begin
          if (push && bus.instr_in == HALT_WORD) begin
            state  <= FROZEN;
            frozen <= 1'b1;
          end
        end
        FROZEN: begin
          if (bus.freeze_clr) begin
            state  <= CAPTURE;
            frozen <= 1'b0;
          end
        end
        default: begin
          state  <= CAPTURE;
          frozen <= 1'b0;
        end
      endcase

      if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;

      if (push) begin
        led_cnt <= LED_W'(STRETCH);
        led     <= 1'b1;
      end else begin
        if (led_cnt != '0) led_cnt <= led_cnt - LED_W'(1);
        led <= (led_cnt > LED_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Bench for instr_trace_buffer: constant vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_instr_trace_buffer;
  localparam int          DEPTH     = 16;
  localparam int          ADDR_W    = 4;
  localparam int          STRETCH   = 8;
  localparam logic [31:0] HALT_WORD = 32'hFC000000;

  logic            CLK = 1'b0;
  logic            reset;
  logic [ADDR_W:0] count;
  logic [15:0]     overflow_cnt;
  logic            frozen;
  logic            led;

  instr_trace_buffer_if bus ();

  instr_trace_buffer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STRETCH(STRETCH), .HALT_WORD(HALT_WORD)
  ) dut (
    .CLK(CLK), .reset(reset), .bus(bus), .count(count),
    .overflow_cnt(overflow_cnt), .frozen(frozen), .led(led)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] mq[$];
  logic [31:0] m_last;
  int          m_ovf;
  bit          m_frozen;
  int          m_led;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic        clr;
    logic        rdy;
    int          exp_count;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_frozen;
    logic        exp_led;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last   = '0;
    m_ovf    = 0;
    m_frozen = 0;
    m_led    = 0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] w, input logic c, input logic r);
    bit p_pop, p_push, p_drop;
    p_pop  = (mq.size() != 0) && r;
    p_push = 0;
    p_drop = 0;
    if (!m_frozen && v) begin
      if (mq.size() < DEPTH || p_pop) p_push = 1;
      else p_drop = 1;
    end
    if (p_pop)  void'(mq.pop_front());
    if (p_push) mq.push_back(w);
    if (p_drop && m_ovf < 65535) m_ovf++;
    if (p_push) m_led = STRETCH;
    else if (m_led > 0) m_led--;
    if (m_frozen && c) m_frozen = 0;
    else if (p_push && w == HALT_WORD) m_frozen = 1;
    if (mq.size() != 0) m_last = mq[0];
  endtask

  task automatic check_model();
    chk("count", 32'(count), 32'(mq.size()));
    chk("rd_valid", 32'(bus.rd_valid), 32'(mq.size() != 0));
    chk("rd_data", bus.rd_data, m_last);
    chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
    chk("frozen", 32'(frozen), 32'(m_frozen));
    chk("led", 32'(led), 32'(m_led != 0));
  endtask

  task automatic cycle(input logic v, input logic [31:0] w, input logic c, input logic r);
    bus.instr_valid = v;
    bus.instr_in    = w;
    bus.freeze_clr  = c;
    bus.rd_ready    = r;
    model_step(v, w, c, r);
    @(posedge CLK);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_in    = '0;
    bus.freeze_clr  = 1'b0;
    bus.rd_ready    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
    model_reset();
    check_model();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int led_hi;
    logic [31:0] w;
    int bias;

    vecs[0]  = '{1'b1, 32'h20080005, 1'b0, 1'b0, 1, 1'b1, 32'h20080005, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1, 1'b1, 32'h20080005, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1, 1'b1, 32'h20080005, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1, 1'b1, 32'h20080005, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1, 1'b1, 32'h20080005, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1, 1'b1, 32'h20080005, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 0, 1'b0, 32'h20080005, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 32'h00000000, 1'b0, 1'b0, 1, 1'b1, 32'h00000000, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, HALT_WORD,    1'b0, 1'b0, 2, 1'b1, 32'h00000000, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 32'h8C090004, 1'b0, 1'b0, 2, 1'b1, 32'h00000000, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 2, 1'b1, 32'h00000000, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 32'h8C090004, 1'b0, 1'b0, 3, 1'b1, 32'h00000000, 1'b0, 1'b1};

    do_reset();
    chk("reset rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("reset count", 32'(count), 32'h0);

    // constant vector table
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].v, vecs[i].instr, vecs[i].clr, vecs[i].rdy);
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d rd_data", i), bus.rd_data, vecs[i].exp_data);
      chk($sformatf("vec%0d frozen", i), 32'(frozen), 32'(vecs[i].exp_frozen));
      chk($sformatf("vec%0d led", i), 32'(led), 32'(vecs[i].exp_led));
      chk($sformatf("vec%0d overflow", i), 32'(overflow_cnt), 32'h0);
    end
    drain();

    // overflow: 20 pushes into 16 slots, then ordered drain
    for (int i = 1; i <= 20; i++) cycle(1'b1, 32'h10000000 + 32'(i), 1'b0, 1'b0);
    chk("ovf count", 32'(count), 32'd16);
    chk("ovf overflow_cnt", 32'(overflow_cnt), 32'd4);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain word %0d", i), bus.rd_data, 32'h10000000 + 32'(i));
      cycle(1'b0, '0, 1'b0, 1'b1);
    end
    chk("drained rd_valid", 32'(bus.rd_valid), 32'h0);

    // full plus simultaneous push and pop
    for (int i = 1; i <= 16; i++) cycle(1'b1, 32'h20000000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'hABCD0001, 1'b0, 1'b1);
    chk("full+pop count", 32'(count), 32'd16);
    chk("full+pop overflow_cnt", 32'(overflow_cnt), 32'd4);
    chk("full+pop head", bus.rd_data, 32'h20000002);
    drain();

    // led stretch: single push, then retrigger 3 cycles later
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    chk("led idle", 32'(led), 32'h0);
    cycle(1'b1, 32'h11111111, 1'b0, 1'b1);
    led_hi = int'(led);
    for (int i = 0; i < 19; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      led_hi += int'(led);
    end
    chk("led single width", 32'(led_hi), 32'd8);
    cycle(1'b1, 32'h22222222, 1'b0, 1'b1);
    led_hi = int'(led);
    cycle(1'b0, '0, 1'b0, 1'b1);
    led_hi += int'(led);
    cycle(1'b0, '0, 1'b0, 1'b1);
    led_hi += int'(led);
    cycle(1'b1, 32'h33333333, 1'b0, 1'b1);
    led_hi += int'(led);
    for (int i = 0; i < 19; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      led_hi += int'(led);
    end
    chk("led retrigger width", 32'(led_hi), 32'd11);

    // asynchronous reset mid-cycle with count 7, overflow 2, frozen
    do_reset();
    for (int i = 1; i <= 18; i++) cycle(1'b1, 32'h30000000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, HALT_WORD, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("pre-reset count", 32'(count), 32'd7);
    chk("pre-reset overflow_cnt", 32'(overflow_cnt), 32'd2);
    chk("pre-reset frozen", 32'(frozen), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("async rd_data", bus.rd_data, 32'h0);
    chk("async count", 32'(count), 32'h0);
    chk("async overflow_cnt", 32'(overflow_cnt), 32'h0);
    chk("async frozen", 32'(frozen), 32'h0);
    chk("async led", 32'(led), 32'h0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    model_reset();
    check_model();

    // randomized run against the reference model
    for (int blk = 0; blk < 6; blk++) begin
      bias = (blk % 2 == 0) ? 4 : 1;
      for (int i = 0; i < 400; i++) begin
        w = ($urandom_range(0, 9) == 0) ? HALT_WORD : $urandom();
        cycle(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, bias) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
